ram_arbiter: RTL and testbench

Multi-core memory-port arbiter that shares one RAM port among the instruction and data requesters of NCPU cores. Each core's cache level presents independent instruction-read and data-read/write requests. The arbiter grants one transaction at a time: round-robin across cores, data before instruction within a core. It holds the grant until the RAM reports completion, then returns the result with a one-cycle wait release. It sits between the per-core caches and the single cpu_ram_if port in the multicore top level, replacing the single-requester path of the one-core design.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word, RAM handshake state, and arbiter FSM state.
package cpu_types_pkg;

  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after rr, wrapping modulo NCPU.
module rr_arbiter #(
  parameter int NCPU = 2,
  parameter int IDXW = (NCPU > 1) ? $clog2(NCPU) : 1
) (
  input  logic [NCPU-1:0] req,
  input  logic [IDXW-1:0] rr,
  output logic [NCPU-1:0] gnt,
  output logic            vld
);

  always_comb begin
    logic [IDXW-1:0] idx;
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < NCPU; k++) begin
      idx = IDXW'((int'(rr) + k) % NCPU);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port among the instruction/data requesters of NCPU cores.
// Round-robin across cores, data before instruction, grant held until RAM completes.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCPU   = 2,
  parameter int WORD_W = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NCPU-1:0]               iREN,
  input  logic [NCPU-1:0][WORD_W-1:0]   iaddr,
  input  logic [NCPU-1:0]               dREN,
  input  logic [NCPU-1:0]               dWEN,
  input  logic [NCPU-1:0][WORD_W-1:0]   daddr,
  input  logic [NCPU-1:0][WORD_W-1:0]   dstore,
  output logic [NCPU-1:0]               iwait,
  output logic [NCPU-1:0]               dwait,
  output logic [NCPU-1:0][WORD_W-1:0]   iload,
  output logic [NCPU-1:0][WORD_W-1:0]   dload,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  output logic                          ramREN,
  output logic                          ramWEN,
  input  logic [WORD_W-1:0]             ramload,
  input  ramstate_t                     ramstate,
  output logic                          err
);

  localparam int IDXW = (NCPU > 1) ? $clog2(NCPU) : 1;

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] gcore_q, gcore_d;
  logic [IDXW-1:0] rr_q, rr_d;
  logic            gdata_q, gdata_d;

  logic [NCPU-1:0] drq;
  logic [NCPU-1:0] any_req;
  logic [NCPU-1:0] rr_gnt;
  logic            rr_vld;
  logic [IDXW-1:0] pick;
  logic            greq;

  assign drq     = dREN | dWEN;
  assign any_req = drq | iREN;

  // Read data goes to every requester; only the one whose wait drops consumes it.
  assign iload = {NCPU{ramload}};
  assign dload = {NCPU{ramload}};

  rr_arbiter #(
    .NCPU (NCPU),
    .IDXW (IDXW)
  ) u_rr (
    .req (any_req),
    .rr  (rr_q),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  always_comb begin
    pick = '0;
    for (int c = 0; c < NCPU; c++) begin
      if (rr_gnt[c]) pick = IDXW'(c);
    end
  end

  always_comb begin
    state_d  = state_q;
    gcore_d  = gcore_q;
    gdata_d  = gdata_q;
    rr_d     = rr_q;
    iwait    = '1;
    dwait    = '1;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    err      = 1'b0;
    greq     = gdata_q ? drq[gcore_q] : iREN[gcore_q];

    case (state_q)
      IDLE: begin
        if (rr_vld) begin
          gcore_d = pick;
          gdata_d = drq[pick];
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A withdrawn request abandons the transfer without moving the pointer.
        if (!greq) begin
          state_d = IDLE;
        end else begin
          if (gdata_q) begin
            ramaddr  = daddr[gcore_q];
            ramstore = dstore[gcore_q];
            ramWEN   = dWEN[gcore_q];
            ramREN   = dREN[gcore_q] & ~dWEN[gcore_q];
          end else begin
            ramaddr  = iaddr[gcore_q];
            ramREN   = 1'b1;
          end
          if (ramstate == ACCESS || ramstate == ERROR) begin
            if (gdata_q) dwait[gcore_q] = 1'b0;
            else         iwait[gcore_q] = 1'b0;
            err     = (ramstate == ERROR);
            state_d = IDLE;
            rr_d    = (gcore_q == IDXW'(NCPU-1)) ? '0 : gcore_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gcore_q <= '0;
      gdata_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gcore_q <= gcore_d;
      gdata_q <= gdata_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests, a simple RAM responder, release monitor.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NCPU = 2;

  logic                     CLK = 1'b0;
  logic                     nRST;
  logic [NCPU-1:0]          iREN, dREN, dWEN, iwait, dwait;
  logic [NCPU-1:0][31:0]    iaddr, daddr, dstore, iload, dload;
  logic [31:0]              ramaddr, ramstore, ramload;
  logic                     ramREN, ramWEN, err;
  ramstate_t                ramstate;

  typedef struct {
    bit          d;
    int          core;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] store;
    logic [31:0] load;
    bit          e;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   lat = 0;
  bit   err_mode = 1'b0;
  int   last_rel[NCPU];

  ram_arbiter #(.NCPU(NCPU), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: BUSY for 'lat' cycles of an active access, then ACCESS (or ERROR).
  always @(posedge CLK) begin
    if ((ramREN | ramWEN) && ramstate == BUSY) busy_cnt <= busy_cnt + 1;
    else                                       busy_cnt <= 0;
  end
  assign ramstate = !(ramREN | ramWEN) ? FREE :
                    (busy_cnt < lat)   ? BUSY :
                    (err_mode ? ERROR : ACCESS);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic push(bit d, int core, logic [31:0] addr, bit wen, logic [31:0] store,
                      logic [31:0] load, bit e, int gap);
    exp_t x;
    x.d = d; x.core = core; x.addr = addr; x.wen = wen;
    x.store = store; x.load = load; x.e = e; x.gap = gap;
    sb.push_back(x);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Returns one cycle after the completion cycle, i.e. in the following IDLE cycle.
  task automatic wait_done(int core, bit d);
    int n;
    n = 0;
    while (((d ? dwait[core] : iwait[core]) == 1'b1) && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL timeout: core %0d data %0d wait never released", core, d);
    end
    tick;
  endtask

  // Monitor: every completion must match the oldest expected transaction.
  always @(negedge CLK) begin
    int   nrel;
    int   rc;
    bit   rd;
    exp_t e;
    if (nRST) begin
      nrel = 0; rc = 0; rd = 1'b0;
      for (int c = 0; c < NCPU; c++) begin
        if (!iwait[c]) begin nrel++; rc = c; rd = 1'b0; end
        if (!dwait[c]) begin nrel++; rc = c; rd = 1'b1; end
      end
      if (nrel > 1) chk("single_release", nrel, 1);
      if (nrel == 0 && err) chk("err_without_release", 32'(err), 0);
      if (nrel == 1) begin
        if (sb.size() == 0) begin
          chk("unexpected_release", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rel_core", rc, e.core);
          chk("rel_type", 32'(rd), 32'(e.d));
          chk("ramaddr", ramaddr, e.addr);
          chk("ramWEN", 32'(ramWEN), 32'(e.wen));
          chk("ramREN", 32'(ramREN), 32'(!e.wen));
          chk("ramstore", ramstore, e.store);
          chk("load", rd ? dload[rc] : iload[rc], e.load);
          chk("err", 32'(err), 32'(e.e));
          if (e.gap != 0) chk("release_gap", cyc - last_rel[rc], e.gap);
          last_rel[rc] = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0;
    for (int c = 0; c < NCPU; c++) last_rel[c] = 0;
    repeat (2) tick;

    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_err", 32'(err), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    nRST = 1'b1;
    tick;

    // Both cores writing continuously, immediate ACCESS: 0,1,0,1,... every 4th cycle each.
    lat = 0;
    daddr[0] = 32'h100; daddr[1] = 32'h104;
    dstore[0] = 32'hAAAA0000; dstore[1] = 32'hBBBB1111;
    for (int i = 0; i < 6; i++)
      push(1'b1, i % 2, (i % 2) ? 32'h104 : 32'h100, 1'b1,
           (i % 2) ? 32'hBBBB1111 : 32'hAAAA0000, 32'h0, 1'b0, (i < 2) ? 0 : 4);
    dWEN = 2'b11;
    n = 0;
    for (int t = 0; t < 100 && n < 6; t++) begin
      if (dwait != 2'b11) n++;
      tick;
    end
    dWEN = '0;
    dstore = '0;
    chk("alt_count", n, 6);
    tick;

    // Single instruction read, ACCESS on the second GRANT cycle.
    lat = 1;
    ramload = 32'hDEADBEEF;
    iaddr[0] = 32'h40;
    push(1'b0, 0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    iREN[0] = 1'b1;
    tick;
    chk("t1_ren_g1", 32'(ramREN), 1);
    chk("t1_addr_g1", ramaddr, 32'h40);
    chk("t1_iwait_g1", 32'(iwait[0]), 1);
    tick;
    chk("t1_ren_g2", 32'(ramREN), 1);
    chk("t1_addr_g2", ramaddr, 32'h40);
    chk("t1_iwait_g2", 32'(iwait[0]), 0);
    tick;
    iREN[0] = 1'b0;
    chk("t1_ren_idle", 32'(ramREN), 0);
    chk("t1_iwait_idle", 32'(iwait[0]), 1);
    tick;

    // Same core, data and instruction together: data first.
    lat = 0;
    ramload = 32'h11112222;
    iaddr[0] = 32'h10; daddr[0] = 32'h20;
    push(1'b1, 0, 32'h20, 1'b0, 32'h0, 32'h11112222, 1'b0, 0);
    push(1'b0, 0, 32'h10, 1'b0, 32'h0, 32'h11112222, 1'b0, 0);
    iREN[0] = 1'b1; dREN[0] = 1'b1;
    wait_done(0, 1'b1);
    dREN[0] = 1'b0;
    wait_done(0, 1'b0);
    iREN[0] = 1'b0;
    tick;

    // Withdrawn request (rr=1): core 1 granted, drops while BUSY, rr must stay at 1.
    lat = 100;
    daddr[1] = 32'h30; iaddr[0] = 32'h50;
    dREN[1] = 1'b1; iREN[0] = 1'b1;
    tick;
    tick;
    chk("wd_addr", ramaddr, 32'h30);
    chk("wd_ren", 32'(ramREN), 1);
    tick;
    chk("wd_dwait_busy", 32'(dwait[1]), 1);
    dREN[1] = 1'b0;
    iaddr[1] = 32'h60;
    iREN[1] = 1'b1;
    lat = 0;
    ramload = 32'h33334444;
    push(1'b0, 1, 32'h60, 1'b0, 32'h0, 32'h33334444, 1'b0, 0);
    push(1'b0, 0, 32'h50, 1'b0, 32'h0, 32'h33334444, 1'b0, 0);
    #1;
    chk("wd_ren_drop", 32'(ramREN), 0);
    chk("wd_dwait_drop", 32'(dwait[1]), 1);
    wait_done(1, 1'b0);
    iREN[1] = 1'b0;
    wait_done(0, 1'b0);
    iREN[0] = 1'b0;
    tick;

    // ERROR completion on a data read.
    lat = 1;
    err_mode = 1'b1;
    ramload = 32'h5555AAAA;
    daddr[0] = 32'h70;
    push(1'b1, 0, 32'h70, 1'b0, 32'h0, 32'h5555AAAA, 1'b1, 0);
    dREN[0] = 1'b1;
    wait_done(0, 1'b1);
    dREN[0] = 1'b0;
    err_mode = 1'b0;
    chk("err_pulse_end", 32'(err), 0);
    tick;

    // Reset in the middle of a write grant.
    lat = 100;
    daddr[1] = 32'h80; dstore[1] = 32'h55;
    dWEN[1] = 1'b1;
    tick;
    tick;
    chk("rg_wen", 32'(ramWEN), 1);
    chk("rg_store", ramstore, 32'h55);
    nRST = 1'b0;
    #1;
    chk("rg_rst_ren", 32'(ramREN), 0);
    chk("rg_rst_wen", 32'(ramWEN), 0);
    chk("rg_rst_iwait", 32'(iwait), 32'h3);
    chk("rg_rst_dwait", 32'(dwait), 32'h3);
    chk("rg_rst_addr", ramaddr, 0);
    dWEN[1] = 1'b0; dstore[1] = '0;
    iaddr[0] = 32'h90; iaddr[1] = 32'hA0;
    iREN = 2'b11;
    lat = 0;
    ramload = 32'h77778888;
    push(1'b0, 0, 32'h90, 1'b0, 32'h0, 32'h77778888, 1'b0, 0);
    push(1'b0, 1, 32'hA0, 1'b0, 32'h0, 32'h77778888, 1'b0, 0);
    tick;
    tick;
    nRST = 1'b1;
    wait_done(0, 1'b0);
    iREN[0] = 1'b0;
    wait_done(1, 1'b0);
    iREN[1] = 1'b0;

    repeat (3) tick;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
